// File: rtl/seq_write_packer.sv
// seq_write_packer: packs 32-bit upstream words into 128-bit FIFO writes, with flush of partial words
// and per-frame word counting.
module seq_write_packer #(
  parameter logic [23:0] frame_words = 24'd65536
) (
  input  logic         wr_clk,
  input  logic         RST,
  input  logic         s_valid,
  input  logic [31:0]  s_data,
  output logic         s_ready,
  input  logic         flush,
  output logic         wr_en,
  output logic [127:0] din,
  input  logic         fifo_full,
  output logic         frame_done,
  output logic [23:0]  word_count
);
  typedef enum logic {FILL, FLUSH} state_t;
  state_t        state_q, state_d;
  logic [1:0]    lane_q, lane_d, eff_lane;
  logic [95:0]   acc_q, acc_d;
  logic [127:0]  din_q, din_d;
  logic          out_valid_q, out_valid_d;
  logic [23:0]   word_count_q, word_count_d;
  logic          frame_done_q, frame_done_d;
  logic          accept, last;
  assign wr_en      = out_valid_q && !fifo_full;
  assign s_ready    = RST && state_q == FILL && (lane_q != 2'd3 || !out_valid_q || wr_en);
  assign din        = din_q;
  assign frame_done = frame_done_q;
  assign word_count = word_count_q;
  always_comb begin
    accept       = s_valid && s_ready;
    eff_lane     = accept ? lane_q + 2'd1 : lane_q;
    last         = word_count_q == frame_words - 24'd1;
    state_d      = state_q;
    lane_d       = lane_q;
    acc_d        = acc_q;
    din_d        = din_q;
    out_valid_d  = out_valid_q && !wr_en;
    word_count_d = wr_en ? (last ? 24'd0 : word_count_q + 24'd1) : word_count_q;
    frame_done_d = wr_en && last;
    if (accept) begin
      if (lane_q == 2'd3) begin
        din_d       = {s_data, acc_q};
        out_valid_d = 1'b1;
        acc_d       = '0;
        lane_d      = 2'd0;
      end else begin
        acc_d[{lane_q, 5'd0} +: 32] = s_data;
        lane_d                      = lane_q + 2'd1;
      end
    end
    // The accumulator is cleared on every emit, so unfilled lanes of a flushed word read as zero.
    if (state_q == FILL && flush && eff_lane != 2'd0) state_d = FLUSH;
    if (state_q == FLUSH && (!out_valid_q || wr_en)) begin
      din_d       = {32'h0, acc_q};
      out_valid_d = 1'b1;
      acc_d       = '0;
      lane_d      = 2'd0;
      state_d     = FILL;
    end
  end
  always_ff @(posedge wr_clk or negedge RST) begin
    if (!RST) begin
      state_q      <= FILL;
      lane_q       <= 2'd0;
      acc_q        <= 96'h0;
      din_q        <= 128'h0;
      out_valid_q  <= 1'b0;
      word_count_q <= 24'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      din_q        <= din_d;
      out_valid_q  <= out_valid_d;
      word_count_q <= word_count_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_seq_write_packer.sv
// tb_seq_write_packer: directed and randomized checks of seq_write_packer against a word-queue reference model.
module tb_seq_write_packer;
  localparam int FW = 3;
  logic         wr_clk = 0, RST = 0, s_valid = 0, flush = 0, fifo_full = 0;
  logic [31:0]  s_data = 0;
  logic         s_ready, wr_en, frame_done;
  logic [127:0] din;
  logic [23:0]  word_count;
  int           nchk = 0, nerr = 0, stalls = 0, fd_count = 0, n0 = 0, idx = 0;
  logic [31:0]  partial[$];
  logic [127:0] expq[$], wlog[$];
  int           cnt = 0;
  logic         fd_exp = 0;

  seq_write_packer #(.frame_words(24'(FW))) dut (
    .wr_clk(wr_clk), .RST(RST), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .flush(flush), .wr_en(wr_en), .din(din), .fifo_full(fifo_full),
    .frame_done(frame_done), .word_count(word_count));

  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack_partial();
    logic [127:0] w = '0;
    foreach (partial[i]) w[32*i +: 32] = partial[i];
    partial.delete();
    return w;
  endfunction

  // Reference model: a queue of accepted words; every 4 words or a flush of a non-empty queue becomes one write.
  always @(negedge wr_clk) begin
    if (!RST) begin
      check("rst_s_ready", s_ready, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_din", din, 0);
      check("rst_word_count", word_count, 0);
      check("rst_frame_done", frame_done, 0);
      partial.delete();
      expq.delete();
      cnt = 0;
      fd_exp = 0;
    end else begin
      check("frame_done", frame_done, fd_exp);
      check("word_count", word_count, cnt);
      if (frame_done) fd_count++;
      fd_exp = 0;
      if (wr_en) begin
        wlog.push_back(din);
        check("wr_en_while_full", fifo_full, 0);
        check("write_was_expected", expq.size() != 0, 1);
        if (expq.size() != 0) check("din", din, expq.pop_front());
        fd_exp = (cnt == FW - 1);
        cnt = (cnt + 1) % FW;
      end
      if (s_valid && s_ready) begin
        partial.push_back(s_data);
        if (partial.size() == 4) expq.push_back(pack_partial());
      end
      if (flush && partial.size() != 0) expq.push_back(pack_partial());
    end
  end

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    s_valid = 1;
    s_data  = w;
    for (int n = 0; ; n++) begin
      @(negedge wr_clk);
      if (s_ready) break;
      stalls++;
      if (n == 50) begin
        check("push_timeout", s_ready, 1);
        break;
      end
    end
    @(posedge wr_clk);
    #1;
    s_valid = 0;
  endtask

  initial begin
    repeat (3) tick();
    RST = 1;
    @(negedge wr_clk);
    check("ready_after_reset", s_ready, 1);
    tick();
    // streaming
    stalls = 0;
    n0 = wlog.size();
    for (int i = 0; i < 8; i++) push(32'(i));
    repeat (3) tick();
    check("stream_stalls", stalls, 0);
    check("stream_writes", wlog.size() - n0, 2);
    check("stream_w0", wlog[n0], 128'h00000003_00000002_00000001_00000000);
    check("stream_w1", wlog[n0+1], 128'h00000007_00000006_00000005_00000004);
    // back-pressure
    n0 = wlog.size();
    fifo_full = 1;
    idx = 0;
    s_valid = 1;
    s_data = 32'h10;
    repeat (10) begin
      @(negedge wr_clk);
      if (s_ready) idx++;
      tick();
      s_data = 32'h10 + 32'(idx);
    end
    @(negedge wr_clk);
    check("bp_accepted", idx, 7);
    check("bp_s_ready", s_ready, 0);
    check("bp_wr_en", wr_en, 0);
    tick();
    fifo_full = 0;
    for (int n = 0; n < 20 && idx < 8; n++) begin
      @(negedge wr_clk);
      if (s_ready) idx++;
      tick();
    end
    s_valid = 0;
    repeat (3) tick();
    check("bp_writes", wlog.size() - n0, 2);
    check("bp_w0", wlog[n0], 128'h00000013_00000012_00000011_00000010);
    check("bp_w1", wlog[n0+1], 128'h00000017_00000016_00000015_00000014);
    // flush of a partial word
    n0 = wlog.size();
    push(32'hA);
    push(32'hB);
    flush = 1;
    tick();
    flush = 0;
    @(negedge wr_clk);
    check("flush_ready_low", s_ready, 0);
    @(negedge wr_clk);
    check("flush_ready_back", s_ready, 1);
    check("flush_wr_en", wr_en, 1);
    check("flush_din", din, 128'h00000000_00000000_0000000B_0000000A);
    repeat (2) tick();
    check("flush_writes", wlog.size() - n0, 1);
    // flush coinciding with the lane-3 accept
    n0 = wlog.size();
    push(32'h1);
    push(32'h2);
    push(32'h3);
    s_valid = 1;
    s_data = 32'h4;
    flush = 1;
    @(negedge wr_clk);
    check("l3_ready", s_ready, 1);
    tick();
    s_valid = 0;
    flush = 0;
    @(negedge wr_clk);
    check("l3_stays_fill", s_ready, 1);
    check("l3_din", din, 128'h00000004_00000003_00000002_00000001);
    repeat (2) tick();
    flush = 1;
    tick();
    flush = 0;
    repeat (4) tick();
    check("l3_single_write", wlog.size() - n0, 1);
    @(negedge wr_clk);
    check("lane0_flush_ready", s_ready, 1);
    tick();
    // frame wrap
    RST = 0;
    tick();
    RST = 1;
    tick();
    fd_count = 0;
    for (int i = 0; i < 28; i++) push(32'h100 + 32'(i));
    repeat (3) tick();
    check("frame_done_pulses", fd_count, 2);
    check("frame_word_count", word_count, 1);
    // reset mid-word
    push(32'hDEAD0001);
    push(32'hDEAD0002);
    RST = 0;
    n0 = wlog.size();
    #1;
    check("async_rst_din", din, 0);
    repeat (2) tick();
    RST = 1;
    @(negedge wr_clk);
    check("rel_s_ready", s_ready, 1);
    tick();
    for (int i = 0; i < 4; i++) push(32'h50 + 32'(i));
    repeat (2) tick();
    check("rst_mid_writes", wlog.size() - n0, 1);
    check("rst_mid_din", wlog[n0], 128'h00000053_00000052_00000051_00000050);
    // randomized traffic
    repeat (400) begin
      s_valid   = 1'($urandom % 2);
      s_data    = $urandom;
      flush     = ($urandom % 8) == 0;
      fifo_full = ($urandom % 3) == 0;
      tick();
    end
    s_valid = 0;
    flush = 0;
    fifo_full = 0;
    repeat (2) tick();
    flush = 1;
    tick();
    flush = 0;
    repeat (6) tick();
    check("drain_expq_empty", expq.size(), 0);
    check("drain_partial_empty", partial.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
